// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
//
// Multiplexed 4-digit seven-segment display driver. Takes four BCD time digits
// and an 8-bit brightness value and time-multiplexes them onto the board's
// active-low anode and cathode lines. Brightness is PWM within each digit slot.
// The upper four anodes of the 8-digit board are held dark.
//
// Each digit slot is 256 PWM ticks of CLK_DIV clocks each. Tick 0 of every
// slot is always blank. The new cathode pattern reaches the pins during that
// blank tick, so a digit never ghosts into its neighbour.
//
// Parameters:
//   CLK_DIV         clocks per PWM tick (>= 1), default 390 (~1 ms slot @ 100 MHz)
//
// Ports:
//   CLK100MHZ       in   1  system clock, all state on rising edge
//   Reset           in   1  asynchronous, active-high reset
//   BCD3..BCD0      in   4  hours tens / hours units / minutes tens / minutes units
//   PWM             in   8  brightness duty, 0 = dark, 255 = max
//   SegmentDrivers  out  8  anode enables, active-low, bit n = digit n
//   SevenSegment    out  8  cathodes, active-low, {dp,g,f,e,d,c,b,a}
//
// Configuration macro:
//   SS_LEADING_ZERO_BLANK_EN  when defined, a zero hours-tens digit is shown
//                             dark. Its anode still pulses, so timing is
//                             unchanged.
// -----------------------------------------------------------------------------
module seven_seg_scanner #(
    parameter int unsigned CLK_DIV = 390
) (
    input  logic       CLK100MHZ,
    input  logic       Reset,
    input  logic [3:0] BCD3,
    input  logic [3:0] BCD2,
    input  logic [3:0] BCD1,
    input  logic [3:0] BCD0,
    input  logic [7:0] PWM,
    output logic [7:0] SegmentDrivers,
    output logic [7:0] SevenSegment
);

    localparam int unsigned     PRE_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic [1:0]       dig_q, dig_d;
    logic [7:0]       duty_q, duty_d;
    logic [7:0]       seg_q, seg_d;
    logic [7:0]       an_out_q, an_out_d;
    logic [7:0]       seg_out_q, seg_out_d;

    logic             tick;
    logic             slot_start;
    logic             lit;
    logic [3:0]       bcd_sel;

    // Active-low seven-segment decode with dp off. Non-decimal codes show a dash.
    function automatic logic [7:0] decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    decode = 8'hC0;
            4'd1:    decode = 8'hF9;
            4'd2:    decode = 8'hA4;
            4'd3:    decode = 8'hB0;
            4'd4:    decode = 8'h99;
            4'd5:    decode = 8'h92;
            4'd6:    decode = 8'h82;
            4'd7:    decode = 8'hF8;
            4'd8:    decode = 8'h80;
            4'd9:    decode = 8'h90;
            default: decode = 8'hBF;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        pre_d      = pre_q;
        pwm_cnt_d  = pwm_cnt_q;
        dig_d      = dig_q;
        duty_d     = duty_q;
        seg_d      = seg_q;
        slot_start = 1'b0;

        tick = (pre_q == PRE_MAX);
        if (tick) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end

        if (tick) begin
            pwm_cnt_d = pwm_cnt_q + 8'd1;
            // A slot starts on the edge where pwm_cnt wraps to 0. Coming out
            // of reset, pwm_cnt is already 0 without wrapping. For that reason
            // the first slot after reset keeps duty = 0 and stays dark.
            if (pwm_cnt_q == 8'hFF) begin
                dig_d      = dig_q + 2'd1;
                slot_start = 1'b1;
            end
        end

        // The digit source follows the new index, so the pattern latched at
        // slot start belongs to the digit that slot displays.
        case (dig_d)
            2'd0:    bcd_sel = BCD0;
            2'd1:    bcd_sel = BCD1;
            2'd2:    bcd_sel = BCD2;
            default: bcd_sel = BCD3;
        endcase

        if (slot_start) begin
            duty_d = PWM;
            seg_d  = decode(bcd_sel);
`ifdef SS_LEADING_ZERO_BLANK_EN
            if ((dig_d == 2'd3) && (BCD3 == 4'd0)) begin
                seg_d = 8'hFF;
            end
`endif
        end

        // pwm_cnt = 0 is never lit. That tick covers the cathode change.
        lit       = (pwm_cnt_q != 8'd0) && (pwm_cnt_q <= duty_q);
        an_out_d  = lit ? ~(8'b1 << dig_q) : 8'hFF;
        seg_out_d = seg_q;
    end

    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples the pre-edge values, whatever order the statements are in.
    always_ff @(posedge CLK100MHZ or posedge Reset) begin
        if (Reset) begin
            pre_q     <= '0;
            pwm_cnt_q <= 8'd0;
            dig_q     <= 2'd0;
            duty_q    <= 8'd0;
            seg_q     <= 8'hFF;
            an_out_q  <= 8'hFF;
            seg_out_q <= 8'hFF;
        end else begin
            pre_q     <= pre_d;
            pwm_cnt_q <= pwm_cnt_d;
            dig_q     <= dig_d;
            duty_q    <= duty_d;
            seg_q     <= seg_d;
            an_out_q  <= an_out_d;
            seg_out_q <= seg_out_d;
        end
    end

    assign SegmentDrivers = an_out_q;
    assign SevenSegment   = seg_out_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scanner
//
// Directed bench for seven_seg_scanner with CLK_DIV = 1 (256-clock slots).
// After reset release, slot n starts at rising edge 256*n. Each slot is
// observed over the 256 following edges, sampled on the falling edge. For each
// slot the bench checks:
//   - the number of lit clocks,
//   - the anode and cathode values seen while lit,
//   - the cathode value at the end of the slot.
// -----------------------------------------------------------------------------
module tb_seven_seg_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] bcd3, bcd2, bcd1, bcd0;
    logic [7:0] pwm;
    logic [7:0] an;
    logic [7:0] seg;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef SS_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] LZ_SEG = 8'hFF;
`else
    localparam logic [7:0] LZ_SEG = 8'hC0;
`endif

    seven_seg_scanner #(.CLK_DIV(1)) dut (
        .CLK100MHZ      (clk),
        .Reset          (rst),
        .BCD3           (bcd3),
        .BCD2           (bcd2),
        .BCD1           (bcd1),
        .BCD0           (bcd0),
        .PWM            (pwm),
        .SegmentDrivers (an),
        .SevenSegment   (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observe one full slot. Optionally drive PWM to chg_val after edge chg_at
    // of the slot, to show that a mid-slot change is deferred.
    task automatic run_slot(input string tag, input int exp_low,
                            input logic [7:0] exp_an, input logic [7:0] exp_seg,
                            input int chg_at = -1, input logic [7:0] chg_val = 8'h00);
        int low = 0;
        int bad = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            if (i == chg_at) begin
                #1 pwm = chg_val;
            end
            @(negedge clk);
            if (an !== 8'hFF) begin
                low++;
                if ((an !== exp_an) || (seg !== exp_seg)) bad++;
            end
        end
        check({tag, " lit clocks"}, low, exp_low);
        check({tag, " an/seg while lit"}, bad, 0);
        check({tag, " seg"}, seg, exp_seg);
    endtask

    initial begin
        rst  = 1'b1;
        pwm  = 8'd255;
        bcd3 = 4'd1; bcd2 = 4'd2; bcd1 = 4'd3; bcd0 = 4'd4;

        repeat (3) @(negedge clk);
        check("reset an", an, 8'hFF);
        check("reset seg", seg, 8'hFF);
        rst = 1'b0;

        // First slot after reset is digit 0 with duty 0.
        run_slot("s0 dark",  0,   8'hFF, 8'hFF);
        run_slot("s1 d1",    255, 8'hFD, 8'hB0);
        run_slot("s2 d2",    255, 8'hFB, 8'hA4);
        run_slot("s3 d3",    255, 8'hF7, 8'hF9);
        run_slot("s4 d0",    255, 8'hFE, 8'h99);

        pwm = 8'd64;
        run_slot("s5 d1",    255, 8'hFD, 8'hB0);
        run_slot("s6 pwm64", 64,  8'hFB, 8'hA4);
        pwm = 8'd0;
        run_slot("s7 pwm64", 64,  8'hF7, 8'hF9);
        run_slot("s8 pwm0",  0,   8'hFF, 8'h99);
        run_slot("s9 pwm0",  0,   8'hFF, 8'hB0);
        run_slot("s10 pwm0", 0,   8'hFF, 8'hA4);
        run_slot("s11 pwm0", 0,   8'hFF, 8'hF9);

        pwm  = 8'd255;
        bcd1 = 4'hB;
        run_slot("s12 d0",   0,   8'hFF, 8'h99);
        run_slot("s13 dash", 255, 8'hFD, 8'hBF);
        run_slot("s14 midchg", 255, 8'hFB, 8'hA4, 100, 8'd16);
        run_slot("s15 pwm16", 16, 8'hF7, 8'hF9);

        bcd3 = 4'd0;
        run_slot("s16 d0",   16,  8'hFE, 8'h99);
        run_slot("s17 d1",   16,  8'hFD, 8'hBF);
        run_slot("s18 d2",   16,  8'hFB, 8'hA4);
        run_slot("s19 lz",   16,  8'hF7, LZ_SEG);

        bcd3 = 4'd8; bcd2 = 4'd7; bcd1 = 4'd6; bcd0 = 4'd5;
        run_slot("s20 d0",   16,  8'hFE, 8'h99);
        run_slot("s21 six",  16,  8'hFD, 8'h82);
        run_slot("s22 seven",16,  8'hFB, 8'hF8);
        run_slot("s23 eight",16,  8'hF7, 8'h80);
        run_slot("s24 five", 16,  8'hFE, 8'h92);

        bcd3 = 4'd9; bcd2 = 4'd0; bcd1 = 4'hF; bcd0 = 4'hC;
        run_slot("s25 d1",   16,  8'hFD, 8'h82);
        run_slot("s26 zero", 16,  8'hFB, 8'hC0);
        run_slot("s27 nine", 16,  8'hF7, 8'h90);
        run_slot("s28 dashC",16,  8'hFE, 8'hBF);

        // Mid-slot asynchronous reset while digit 1 is lit.
        repeat (10) @(posedge clk);
        #1;
        check("pre-reset lit an", an, 8'hFD);
        #1 rst = 1'b1;
        #1;
        check("async reset an", an, 8'hFF);
        check("async reset seg", seg, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        run_slot("r0 dark",  0,   8'hFF, 8'hFF);
        run_slot("r1 d1",    16,  8'hFD, 8'hBF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
